pe_mac_stream: RTL and testbench

Parametrised output-stationary processing element for the next-generation systolic array. Each cycle it forwards its A and B operands to its right and lower neighbours and, when both operands are valid, multiply-accumulates them into a local accumulator. It supports configurable operand and accumulator widths, signed or unsigned arithmetic, and optional saturation. A tile ends on a `last` marker; the final sum is then moved into a result register drained by a valid/ready handshake, so the next tile can accumulate while the previous result waits.

---
 rtl/pe_stream_pkg.sv | 26 ++
 rtl/pe_sat_add.sv | 42 ++++
 rtl/pe_mac_stream.sv | 156 +++++++++++++++
 tb/tb_pe_mac_stream.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/pe_stream_pkg.sv
// Shared types and constants for the streaming MAC processing element.
package pe_stream_pkg;

  typedef enum logic [0:0] {IDLE, ACC} pe_state_t;

  // Widest accumulator the limit helper can describe.
  localparam int unsigned MaxAccW = 128;

  // Largest (want_max=1) or smallest (want_max=0) value of an acc_w-bit accumulator.
  function automatic logic [MaxAccW-1:0] acc_limit(input int unsigned acc_w, input bit is_signed,
                                                   input bit want_max);
    logic [MaxAccW-1:0] lim;
    logic [MaxAccW-1:0] one;
    lim = '0;
    one = MaxAccW'(1);
    for (int unsigned i = 0; i < MaxAccW; i++) begin
      if (i < acc_w && want_max) lim = lim | (one << i);
      if (is_signed && i == acc_w - 1) begin
        if (want_max) lim = lim & ~(one << i);
        else          lim = lim | (one << i);
      end
    end
    return lim;
  endfunction

endpackage

// File: rtl/pe_sat_add.sv
// Combinational accumulator adder with overflow detect and optional clamping.
module pe_sat_add
  import pe_stream_pkg::*;
#(
  parameter int unsigned ACC_W    = 32,
  parameter bit          SIGNED   = 1'b0,
  parameter bit          SATURATE = 1'b1
) (
  input  logic [ACC_W-1:0] i_a,
  input  logic [ACC_W-1:0] i_b,
  output logic [ACC_W-1:0] o_sum,
  output logic             o_ovf
);

  localparam logic [ACC_W-1:0] AccMax = ACC_W'(acc_limit(ACC_W, SIGNED, 1'b1));
  localparam logic [ACC_W-1:0] AccMin = ACC_W'(acc_limit(ACC_W, SIGNED, 1'b0));

  logic [ACC_W:0] full;
  logic           ovf;
  logic           ovf_high;

  assign full = {1'b0, i_a} + {1'b0, i_b};

  if (SIGNED) begin : g_signed
    logic unused_carry;
    assign unused_carry = full[ACC_W];
    // Operands agree in sign but the result does not.
    assign ovf      = (i_a[ACC_W-1] == i_b[ACC_W-1]) && (full[ACC_W-1] != i_a[ACC_W-1]);
    assign ovf_high = ~i_a[ACC_W-1];
  end else begin : g_unsigned
    assign ovf      = full[ACC_W];
    assign ovf_high = 1'b1;
  end

  always_comb begin
    o_sum = full[ACC_W-1:0];
    if (SATURATE && ovf) o_sum = ovf_high ? AccMax : AccMin;
  end

  assign o_ovf = ovf;

endmodule

// File: rtl/pe_mac_stream.sv
// Output-stationary systolic PE: forwards A/B operands and accumulates their products
// per tile, handing each tile sum to a valid/ready result register.
module pe_mac_stream
  import pe_stream_pkg::*;
#(
  parameter int unsigned A_W      = 8,
  parameter int unsigned B_W      = 8,
  parameter int unsigned ACC_W    = 32,
  parameter bit          SIGNED   = 1'b0,
  parameter bit          SATURATE = 1'b1
) (
  input  logic             i_clk,
  input  logic             i_arst,
  input  logic [A_W-1:0]   i_a,
  input  logic             i_aValid,
  input  logic             i_aLast,
  input  logic [B_W-1:0]   i_b,
  input  logic             i_bValid,
  output logic [A_W-1:0]   o_a,
  output logic             o_aValid,
  output logic             o_aLast,
  output logic [B_W-1:0]   o_b,
  output logic             o_bValid,
  output logic [ACC_W-1:0] o_y,
  output logic             o_yValid,
  input  logic             i_yReady,
  output logic             o_yOvf,
  output logic             o_busy,
  output logic             o_err
);

  localparam int unsigned PW = A_W + B_W;

  pe_state_t        state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             ovf_q, ovf_d;
  logic [ACC_W-1:0] y_q, y_d;
  logic             y_valid_q, y_valid_d, y_ovf_q, y_ovf_d, err_q, err_d;
  logic [ACC_W-1:0] product, sum;
  logic             add_ovf, fire, tile_end, tile_ovf;

  if (SIGNED) begin : g_signed
    logic signed [PW-1:0] a_ext, b_ext, prod;
    assign a_ext   = $signed({{B_W{i_a[A_W-1]}}, i_a});
    assign b_ext   = $signed({{A_W{i_b[B_W-1]}}, i_b});
    assign prod    = a_ext * b_ext;
    assign product = ACC_W'(prod);
  end else begin : g_unsigned
    logic [PW-1:0] prod;
    assign prod    = {{B_W{1'b0}}, i_a} * {{A_W{1'b0}}, i_b};
    assign product = ACC_W'(prod);
  end

  // acc_q is zero in IDLE, so the same adder also starts a fresh tile.
  pe_sat_add #(
    .ACC_W   (ACC_W),
    .SIGNED  (SIGNED),
    .SATURATE(SATURATE)
  ) u_add (
    .i_a  (acc_q),
    .i_b  (product),
    .o_sum(sum),
    .o_ovf(add_ovf)
  );

  assign fire     = i_aValid & i_bValid;
  assign tile_end = fire & i_aLast;
  assign tile_ovf = ovf_q | add_ovf;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (fire && !i_aLast) begin
          state_d = ACC;
          acc_d   = sum;
          ovf_d   = add_ovf;
        end
      end
      ACC: begin
        if (fire) begin
          if (i_aLast) begin
            state_d = IDLE;
            acc_d   = '0;
            ovf_d   = 1'b0;
          end else begin
            acc_d = sum;
            ovf_d = tile_ovf;
          end
        end
      end
      default: begin
        state_d = IDLE;
        acc_d   = '0;
        ovf_d   = 1'b0;
      end
    endcase
  end

  always_comb begin
    y_d       = y_q;
    y_valid_d = y_valid_q;
    y_ovf_d   = y_ovf_q;
    err_d     = err_q | (i_aValid ^ i_bValid);
    if (tile_end) begin
      if (!y_valid_q || i_yReady) begin
        y_d       = sum;
        y_ovf_d   = tile_ovf;
        y_valid_d = 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end else if (y_valid_q && i_yReady) begin
      y_valid_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_arst) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      ovf_q     <= 1'b0;
      y_q       <= '0;
      y_valid_q <= 1'b0;
      y_ovf_q   <= 1'b0;
      err_q     <= 1'b0;
      o_a       <= '0;
      o_aValid  <= 1'b0;
      o_aLast   <= 1'b0;
      o_b       <= '0;
      o_bValid  <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      ovf_q     <= ovf_d;
      y_q       <= y_d;
      y_valid_q <= y_valid_d;
      y_ovf_q   <= y_ovf_d;
      err_q     <= err_d;
      o_aValid  <= i_aValid;
      o_aLast   <= i_aValid & i_aLast;
      o_bValid  <= i_bValid;
      if (i_aValid) o_a <= i_a;
      if (i_bValid) o_b <= i_b;
    end
  end

  assign o_y      = y_q;
  assign o_yValid = y_valid_q;
  assign o_yOvf   = y_ovf_q;
  assign o_busy   = (state_q == ACC);
  assign o_err    = err_q;

endmodule

// File: tb/tb_pe_mac_stream.sv
// Directed bench for pe_mac_stream: four parameterisations share one stimulus stream.
module tb_pe_mac_stream;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] a, b;
  logic       av, al, bv, ready;

  // Instance index: 0 default, 1 signed, 2 16-bit saturating, 3 16-bit wrapping.
  logic [7:0]  fa [4];
  logic [7:0]  fb [4];
  logic        fav[4];
  logic        fal[4];
  logic        fbv[4];
  logic        yv [4];
  logic        yo [4];
  logic        bz [4];
  logic        er [4];
  logic [31:0] y32[2];
  logic [15:0] y16[2];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pe_mac_stream u_dut (
    .i_clk(clk), .i_arst(rst), .i_a(a), .i_aValid(av), .i_aLast(al), .i_b(b), .i_bValid(bv),
    .o_a(fa[0]), .o_aValid(fav[0]), .o_aLast(fal[0]), .o_b(fb[0]), .o_bValid(fbv[0]),
    .o_y(y32[0]), .o_yValid(yv[0]), .i_yReady(ready), .o_yOvf(yo[0]), .o_busy(bz[0]),
    .o_err(er[0])
  );

  pe_mac_stream #(.SIGNED(1'b1)) u_sgn (
    .i_clk(clk), .i_arst(rst), .i_a(a), .i_aValid(av), .i_aLast(al), .i_b(b), .i_bValid(bv),
    .o_a(fa[1]), .o_aValid(fav[1]), .o_aLast(fal[1]), .o_b(fb[1]), .o_bValid(fbv[1]),
    .o_y(y32[1]), .o_yValid(yv[1]), .i_yReady(ready), .o_yOvf(yo[1]), .o_busy(bz[1]),
    .o_err(er[1])
  );

  pe_mac_stream #(.ACC_W(16), .SATURATE(1'b1)) u_sat16 (
    .i_clk(clk), .i_arst(rst), .i_a(a), .i_aValid(av), .i_aLast(al), .i_b(b), .i_bValid(bv),
    .o_a(fa[2]), .o_aValid(fav[2]), .o_aLast(fal[2]), .o_b(fb[2]), .o_bValid(fbv[2]),
    .o_y(y16[0]), .o_yValid(yv[2]), .i_yReady(ready), .o_yOvf(yo[2]), .o_busy(bz[2]),
    .o_err(er[2])
  );

  pe_mac_stream #(.ACC_W(16), .SATURATE(1'b0)) u_wrap16 (
    .i_clk(clk), .i_arst(rst), .i_a(a), .i_aValid(av), .i_aLast(al), .i_b(b), .i_bValid(bv),
    .o_a(fa[3]), .o_aValid(fav[3]), .o_aLast(fal[3]), .o_b(fb[3]), .o_bValid(fbv[3]),
    .o_y(y16[1]), .o_yValid(yv[3]), .i_yReady(ready), .o_yOvf(yo[3]), .o_busy(bz[3]),
    .o_err(er[3])
  );

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic va, input logic vb, input logic last,
                       input logic [7:0] da, input logic [7:0] db);
    av = va; bv = vb; al = last; a = da; b = db;
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    ready = 1'b0;
    do_reset();
    checks++; if (y32[0] !== 32'd0) begin errors++; $display("FAIL reset_y: got %0d want 0", y32[0]); end
    checks++; if (yv[0] !== 1'b0) begin errors++; $display("FAIL reset_yvalid: got %b want 0", yv[0]); end
    checks++; if (er[0] !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", er[0]); end
    checks++; if ({fav[0], fal[0], fbv[0], bz[0], yo[0]} !== 5'b0) begin
      errors++; $display("FAIL reset_flags: got %b want 00000", {fav[0], fal[0], fbv[0], bz[0], yo[0]});
    end
    checks++; if ({fa[0], fb[0]} !== 16'd0) begin errors++; $display("FAIL reset_fwd: got %h want 0", {fa[0], fb[0]}); end
  endtask

  task automatic test_unsigned_tile();
    ready = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 8'd2, 8'd3);
    #1;
    checks++; if (fav[0] !== 1'b0) begin errors++; $display("FAIL fwd_early: got %b want 0", fav[0]); end
    cyc();
    checks++; if ({fav[0], fbv[0], fa[0], fb[0]} !== {1'b1, 1'b1, 8'd2, 8'd3}) begin
      errors++; $display("FAIL fwd_t1: got a=%0d b=%0d want 2 3", fa[0], fb[0]);
    end
    checks++; if (bz[0] !== 1'b1) begin errors++; $display("FAIL busy_t1: got %b want 1", bz[0]); end
    drive(1'b1, 1'b1, 1'b0, 8'd4, 8'd5);
    cyc();
    checks++; if (fa[0] !== 8'd4) begin errors++; $display("FAIL fwd_t2: got %0d want 4", fa[0]); end
    drive(1'b1, 1'b1, 1'b1, 8'd1, 8'd7);
    cyc();
    drive(1'b0, 1'b0, 1'b0, 8'd9, 8'd9);
    checks++; if (yv[0] !== 1'b1) begin errors++; $display("FAIL tile_yvalid: got %b want 1", yv[0]); end
    checks++; if (y32[0] !== 32'd33) begin errors++; $display("FAIL tile_y: got %0d want 33", y32[0]); end
    checks++; if (yo[0] !== 1'b0) begin errors++; $display("FAIL tile_ovf: got %b want 0", yo[0]); end
    checks++; if (fal[0] !== 1'b1) begin errors++; $display("FAIL fwd_last: got %b want 1", fal[0]); end
    checks++; if (bz[0] !== 1'b0) begin errors++; $display("FAIL busy_end: got %b want 0", bz[0]); end
    cyc();
    checks++; if ({fav[0], fa[0]} !== {1'b0, 8'd1}) begin
      errors++; $display("FAIL fwd_hold: got v=%b a=%0d want 0 1", fav[0], fa[0]);
    end
    checks++; if (yv[0] !== 1'b1) begin errors++; $display("FAIL hold_yvalid: got %b want 1", yv[0]); end
    ready = 1'b1;
    cyc();
    checks++; if ({yv[0], y32[0]} !== {1'b0, 32'd33}) begin
      errors++; $display("FAIL accept: got v=%b y=%0d want 0 33", yv[0], y32[0]);
    end
  endtask

  task automatic test_signed();
    ready = 1'b1;
    do_reset();
    drive(1'b1, 1'b1, 1'b0, 8'h80, 8'h7F);
    cyc();
    drive(1'b1, 1'b1, 1'b1, 8'hFF, 8'hFF);
    cyc();
    drive(1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
    checks++; if (y32[1] !== 32'hFFFF_C081) begin
      errors++; $display("FAIL signed_y: got %0d want -16255", $signed(y32[1]));
    end
    checks++; if ({yv[1], yo[1]} !== 2'b10) begin
      errors++; $display("FAIL signed_flags: got %b want 10", {yv[1], yo[1]});
    end
  endtask

  task automatic test_saturate();
    ready = 1'b1;
    do_reset();
    drive(1'b1, 1'b1, 1'b0, 8'd255, 8'd255);
    cyc();
    drive(1'b1, 1'b1, 1'b1, 8'd255, 8'd255);
    cyc();
    drive(1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
    checks++; if ({y16[0], yo[2]} !== {16'd65535, 1'b1}) begin
      errors++; $display("FAIL sat_y: got y=%0d ovf=%b want 65535 1", y16[0], yo[2]);
    end
    checks++; if ({y16[1], yo[3]} !== {16'd64514, 1'b1}) begin
      errors++; $display("FAIL wrap_y: got y=%0d ovf=%b want 64514 1", y16[1], yo[3]);
    end
  endtask

  task automatic test_backpressure();
    ready = 1'b0;
    do_reset();
    drive(1'b1, 1'b1, 1'b1, 8'd3, 8'd3);
    cyc();
    checks++; if ({yv[0], y32[0], er[0]} !== {1'b1, 32'd9, 1'b0}) begin
      errors++; $display("FAIL bp_first: got v=%b y=%0d err=%b want 1 9 0", yv[0], y32[0], er[0]);
    end
    drive(1'b1, 1'b1, 1'b1, 8'd4, 8'd4);
    cyc();
    drive(1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
    checks++; if ({yv[0], y32[0], er[0]} !== {1'b1, 32'd9, 1'b1}) begin
      errors++; $display("FAIL bp_drop: got v=%b y=%0d err=%b want 1 9 1", yv[0], y32[0], er[0]);
    end
    ready = 1'b1;
    cyc();
    checks++; if ({yv[0], er[0]} !== 2'b01) begin
      errors++; $display("FAIL bp_release: got v=%b err=%b want 0 1", yv[0], er[0]);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] want[3];
    want[0] = 32'd1; want[1] = 32'd4; want[2] = 32'd9;
    ready = 1'b1;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 1'b1, 8'(i + 1), 8'(i + 1));
      cyc();
      checks++; if ({yv[0], y32[0]} !== {1'b1, want[i]}) begin
        errors++; $display("FAIL b2b_%0d: got v=%b y=%0d want 1 %0d", i, yv[0], y32[0], want[i]);
      end
    end
    // A last marker without a valid A is neither accumulated nor forwarded.
    drive(1'b0, 1'b0, 1'b1, 8'd0, 8'd0);
    cyc();
    checks++; if ({yv[0], fal[0], er[0]} !== 3'b000) begin
      errors++; $display("FAIL b2b_idle: got %b want 000", {yv[0], fal[0], er[0]});
    end
  endtask

  task automatic test_err_and_reset();
    ready = 1'b1;
    do_reset();
    drive(1'b1, 1'b1, 1'b0, 8'd2, 8'd3);
    cyc();
    drive(1'b1, 1'b0, 1'b0, 8'd10, 8'd10);
    cyc();
    checks++; if ({er[0], bz[0]} !== 2'b11) begin
      errors++; $display("FAIL err_lone_a: got %b want 11", {er[0], bz[0]});
    end
    drive(1'b1, 1'b1, 1'b1, 8'd1, 8'd1);
    cyc();
    checks++; if (y32[0] !== 32'd7) begin errors++; $display("FAIL err_acc_kept: got %0d want 7", y32[0]); end
    drive(1'b1, 1'b1, 1'b0, 8'd5, 8'd5);
    cyc();
    drive(1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    checks++; if ({y32[0], yv[0], er[0], bz[0], fav[0], fa[0], fb[0]} !== '0) begin
      errors++; $display("FAIL midreset: got y=%0d v=%b err=%b busy=%b a=%0d want all 0",
                         y32[0], yv[0], er[0], bz[0], fa[0]);
    end
    drive(1'b1, 1'b1, 1'b1, 8'd1, 8'd2);
    cyc();
    checks++; if ({yv[0], y32[0]} !== {1'b1, 32'd2}) begin
      errors++; $display("FAIL post_reset_tile: got v=%b y=%0d want 1 2", yv[0], y32[0]);
    end
  endtask

  initial begin
    rst = 1'b1;
    ready = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
    test_reset();
    test_unsigned_tile();
    test_signed();
    test_saturate();
    test_backpressure();
    test_back_to_back();
    test_err_and_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
